shared_line_arbiter: RTL and testbench
======================================

Name: shared_line_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared single-bit output line, such as a shared enable or trigger pin into the PL/PS boundary.
- Up to N_REQ requesters compete for the line. The winner's data bit is gated onto the line; the line is forced to 0 whenever nobody owns it.
- Each ownership is bounded by MAX_HOLD cycles and followed by a GAP_CYC-cycle dead time. This gives fairness and a guaranteed low gap between owners.

Parameters:
- N_REQ, 4, number of requesters. Legal range is 2 to 16.
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership. Must be at least 1.
- GAP_CYC, 2, dead cycles with line low between ownerships. Must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; held high for as long as ownership is wanted.
- din  in  N_REQ  per-requester data bit to drive onto the line while owner.
- gnt  out  N_REQ  registered one-hot grant; all zero when nobody owns the line.
- owner_id  out  $clog2(N_REQ)  registered index of the current or most recent owner.
- busy  out  1  registered; high exactly while in GRANT.
- line_out  out  1  shared line; combinational busy & din[owner_id], otherwise 0.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - state = IDLE, gnt = 0, busy = 0, line_out = 0, owner_id = 0.
  - hold_cnt = 0, gap_cnt = 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has highest priority first.
- Arbitration function: first i with req[i] = 1, searching (last+1) mod N_REQ upward with wrap-around.
- States:
  - IDLE: gnt = 0. If any req is sampled high at edge k, go to GRANT at edge k, with gnt/owner_id/busy valid from edge k. Latency is 1 cycle from req to gnt. last <= winner.
  - GRANT:
    - hold_cnt increments each cycle, starting at 1 in the first grant cycle.
    - Exit at the edge where req[owner] is sampled low, or where hold_cnt == MAX_HOLD. That gives at most MAX_HOLD grant cycles.
    - On exit: gnt = 0, busy = 0, hold_cnt = 0, go to GAP.
    - din changes pass to line_out with zero latency while granted.
  - GAP:
    - line_out = 0 and gnt = 0 for exactly GAP_CYC cycles; gap_cnt counts 1 to GAP_CYC.
    - On the last GAP cycle, if any req is high, arbitrate and enter GRANT directly with no extra IDLE cycle. Otherwise go to IDLE.
- Fairness:
  - The pointer advances at every grant.
  - An owner expired by MAX_HOLD that keeps req high yields to any other pending requester.
  - If it is the sole requester, it regains the line after GAP_CYC cycles.
- Request timing:
  - A requester dropping req mid-grant releases the line at that edge.
  - req changes of non-owners during GRANT have no effect on the current ownership.
- Simultaneous release and new requests: the release is honoured first. The new requests are arbitrated only at the end of GAP.
- owner_id retains its last value in IDLE and GAP.
- Counter widths: hold_cnt is $clog2(MAX_HOLD+1) bits; gap_cnt is $clog2(GAP_CYC+1) bits. No wrap is possible because both saturate at their exit comparison.
- Reset mid-GRANT or mid-GAP: line_out drops to 0 asynchronously and all state returns to reset values. After rst_n deasserts, requester 0 again has top priority.
- Invariants checked by the bench: gnt is one-hot or zero, busy == |gnt, and line_out == 0 whenever busy == 0.

Test Plan:
- Reset then single request: req=0001, din[0] toggling.
  - gnt=0001 one cycle after req and line_out follows din[0].
  - Drop req → busy=0 next edge, line_out=0 for 2 cycles, then IDLE.
- Simultaneous request: req=1111 from reset, all held.
  - Grants in order 0,1,2,3,0. Each lasts 16 cycles, separated by 2-cycle gaps.
  - owner_id sequence is 0,1,2,3,0.
- MAX_HOLD expiry, sole requester: req=0100 held high with din[2]=1.
  - line_out pattern: 16 high, 2 low, repeating.
  - gnt=0100 each time.
- Early release with contention: owner 1 drops req after 3 cycles while req[3] is high.
  - Grant 1 lasts 3 cycles, then 2 gap cycles, then gnt=1000 on the edge ending the gap.
- Asynchronous reset mid-grant: assert rst_n low mid-cycle during gnt=0010.
  - gnt, busy and line_out go to 0 immediately.
  - After release with req=1010, the grant goes to requester 1 first (pointer at N_REQ-1, so search starts at 0).
- Non-owner noise: during owner 0's grant, toggle req[1] and req[2] every cycle.
  - Grant 0 is unaffected and lasts its full duration.
  - After the gap, the next winner is the requester high on the final gap edge at or after index 1.

Source files
------------

// File: rtl/shared_line_arbiter.sv
// Round-robin arbiter for one shared single-bit line.
// Each ownership lasts at most MAX_HOLD cycles and is followed by GAP_CYC dead cycles.
module shared_line_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  parameter int GAP_CYC  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         din,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     busy,
  output logic                     line_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD);
  localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYC);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic          win_valid;
  logic [IW-1:0] win_idx;

  // First requester at or after last+1, wrapping around.
  always_comb begin
    int idx;
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(last) + 1 + i) % N_REQ;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner_id <= '0;
      busy     <= 1'b0;
      last     <= IW'(N_REQ - 1);
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= GRANT;
            gnt      <= ONE_HOT0 << win_idx;
            owner_id <= win_idx;
            busy     <= 1'b1;
            last     <= win_idx;
            hold_cnt <= HW'(1);
          end
        end
        GRANT: begin
          if (!req[owner_id] || hold_cnt == HOLD_LAST) begin
            state    <= GAP;
            gnt      <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= GW'(1);
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            // Requests pending at the end of the dead time go straight to GRANT.
            if (win_valid) begin
              state    <= GRANT;
              gnt      <= ONE_HOT0 << win_idx;
              owner_id <= win_idx;
              busy     <= 1'b1;
              last     <= win_idx;
              hold_cnt <= HW'(1);
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign line_out = busy & din[owner_id];

endmodule

// File: tb/tb_shared_line_arbiter.sv
// Randomized bench for shared_line_arbiter against an ownership-level reference model.
module tb_shared_line_arbiter;

  localparam int N  = 4;
  localparam int MH = 16;
  localparam int GC = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] din;
  logic [N-1:0] gnt;
  logic [1:0]   owner_id;
  logic         busy;
  logic         line_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current owner (-1 = nobody), cycles held, dead cycles left.
  int m_owner, m_held, m_gap_left, m_last, m_id;

  shared_line_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .GAP_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .owner_id(owner_id), .busy(busy), .line_out(line_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_held     = 0;
    m_gap_left = 0;
    m_last     = N - 1;
    m_id       = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from_last);
    for (int k = 1; k <= N; k++) begin
      if (r[(from_last + k) % N]) return (from_last + k) % N;
    end
    return -1;
  endfunction

  task automatic take_line(input int w);
    if (w >= 0) begin
      m_owner = w;
      m_id    = w;
      m_last  = w;
      m_held  = 1;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MH) begin
        m_owner    = -1;
        m_gap_left = GC;
      end else begin
        m_held++;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) take_line(pick(req, m_last));
    end else begin
      take_line(pick(req, m_last));
    end
  endtask

  task automatic compare_all(input string ph);
    logic [N-1:0] e_gnt;
    logic         e_busy;
    e_busy = (m_owner >= 0);
    e_gnt  = e_busy ? (N'(1) << m_owner) : '0;
    check({ph, "_gnt"}, 32'(gnt), 32'(e_gnt));
    check({ph, "_busy"}, 32'(busy), 32'(e_busy));
    check({ph, "_owner"}, 32'(owner_id), 32'(m_id));
    check({ph, "_line"}, 32'(line_out), 32'(e_busy & din[m_id]));
    check({ph, "_onehot0"}, 32'($onehot0(gnt)), 32'(1));
    check({ph, "_busy_or"}, 32'(busy), 32'(|gnt));
    if (!busy) check({ph, "_line_low"}, 32'(line_out), 32'(0));
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic rand_din();
    din = N'($urandom_range(0, (1 << N) - 1));
  endtask

  initial begin
    logic [N-1:0] r;
    bit           got_busy;
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    model_reset();
    repeat (2) cycle("rst");
    check("rst_owner", 32'(owner_id), 32'(0));
    rst_n = 1'b1;

    // Single requester 0 with toggling data, then release.
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin din[0] = i[0]; cycle("single"); end
    req = '0;
    repeat (6) cycle("release");

    // Everyone requesting: full-length grants in round-robin order.
    req = 4'b1111;
    repeat (80) begin rand_din(); cycle("all"); end
    req = '0;
    repeat (4) cycle("all_off");

    // Sole requester expiring and regaining the line.
    req = 4'b0100;
    din = 4'b0100;
    repeat (40) cycle("sole");
    req = '0;
    repeat (4) cycle("sole_off");

    // Early release by owner 1 while 3 waits.
    req = 4'b0010;
    cycle("early");
    req = 4'b1010;
    din = 4'b1010;
    repeat (2) cycle("early");
    req = 4'b1000;
    repeat (6) cycle("early");
    check("early_next", 32'(gnt), 32'(4'b1000));
    req = '0;
    repeat (4) cycle("early_off");

    // Asynchronous reset mid-grant, then 1 vs 3 with fresh pointer.
    req = 4'b1111;
    got_busy = 0;
    for (int i = 0; i < 100 && !got_busy; i++) begin
      cycle("pre_rst");
      got_busy = (m_owner == 1);
    end
    check("pre_rst_reached", 32'(got_busy), 32'(1));
    din = 4'b0010;
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'(0));
    check("async_busy", 32'(busy), 32'(0));
    check("async_line", 32'(line_out), 32'(0));
    model_reset();
    cycle("in_rst");
    rst_n = 1'b1;
    req   = 4'b1010;
    cycle("post_rst");
    check("post_rst_owner", 32'(owner_id), 32'(1));
    repeat (30) begin rand_din(); cycle("post_rst"); end
    req = '0;
    repeat (4) cycle("post_rst_off");

    // Owner 0 with noisy non-owners.
    req = 4'b0001;
    cycle("noise");
    for (int i = 0; i < 30; i++) begin
      req[1] = $urandom_range(0, 1);
      req[2] = $urandom_range(0, 1);
      rand_din();
      cycle("noise");
    end
    req = '0;
    repeat (4) cycle("noise_off");

    // Random sticky requests.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      req = r;
      rand_din();
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
